tv_sync_decoder: RTL and testbench

- Receive-side counterpart of the composite TV-out generator.
- Samples a composite stream (active-low sync level plus 1-bit video) at the same 10 MHz pixel rate, derived from clk by a prescaler.
- Separates horizontal and vertical sync by measuring low-pulse widths, and regenerates xpos/ypos.
- Emits visible pixels with a lock indication; used for loopback self-test of the TV-out path and for capturing external mono composite sources.

---
 rtl/tv_sync_decoder.sv | 170 +++++++++++++++++
 tb/tb_tv_sync_decoder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/tv_sync_decoder.sv
// Composite sync decoder: separates hsync/vsync by low-run width, regenerates
// the raster position and emits visible pixels once timing is locked.
module tv_sync_decoder #(
  parameter int CLK_DIV     = 5,
  parameter int LINE_LEN    = 640,
  parameter int FRAME_LINES = 309,
  parameter int H_VIS       = 492,
  parameter int V_VIS       = 268,
  parameter int H_RISE      = 576,
  parameter int V_RISE_X    = 320,
  parameter int V_RISE_Y    = 272,
  parameter int HS_MIN      = 32,
  parameter int HS_MAX      = 63,
  parameter int VS_MIN      = 256,
  parameter int LOCK_LINES  = 4,
  parameter int TIMEOUT     = 2560
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sync_in_,
  input  logic       video_in,
  output logic       tick,
  output logic       hsync_evt,
  output logic       vsync_evt,
  output logic       locked,
  output logic       pix_valid,
  output logic       pix,
  output logic [9:0] xpos,
  output logic [8:0] ypos
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int LW = $clog2(LOCK_LINES + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [9:0]    X_LAST   = 10'(LINE_LEN - 1);
  localparam logic [9:0]    X_HRISE  = 10'(H_RISE);
  localparam logic [9:0]    X_VRISE  = 10'(V_RISE_X);
  localparam logic [9:0]    X_VIS    = 10'(H_VIS);
  localparam logic [8:0]    Y_LAST   = 9'(FRAME_LINES - 1);
  localparam logic [8:0]    Y_VRISE  = 9'(V_RISE_Y);
  localparam logic [8:0]    Y_VIS    = 9'(V_VIS);
  localparam logic [10:0]   RUN_SAT  = 11'h7ff;
  localparam logic [10:0]   R_HMIN   = 11'(HS_MIN);
  localparam logic [10:0]   R_HMAX   = 11'(HS_MAX);
  localparam logic [10:0]   R_VMIN   = 11'(VS_MIN);
  localparam logic [11:0]   T_LAST   = 12'(TIMEOUT - 1);
  localparam logic [11:0]   T_FULL   = 12'(TIMEOUT);
  localparam logic [LW-1:0] L_FULL   = LW'(LOCK_LINES);

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } pos_t;

  logic [PW-1:0] presc;
  logic [1:0]    sync_pipe, vid_pipe;
  logic          s_prev, seen_v, seen_n, lock_n;
  logic [10:0]   run, run_n;
  logic [11:0]   tcnt, tcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  pos_t          pos, pred, pos_n;
  logic          tick_c, s_cur, v_cur, rise, is_h, is_v, pv_n;

  assign tick_c = (presc == PRE_LAST);
  assign s_cur  = sync_pipe[1];
  assign v_cur  = vid_pipe[1];
  assign rise   = ~s_prev & s_cur;
  assign is_h   = rise && (run >= R_HMIN) && (run <= R_HMAX);
  assign is_v   = rise && (run >= R_VMIN);
  assign xpos   = pos.x;
  assign ypos   = pos.y;

  // Next sample state: run length, position, lock and timeout tracking
  always_comb begin
    run_n  = run;
    tcnt_n = tcnt;
    lcnt_n = lcnt;
    seen_n = seen_v;
    lock_n = locked;
    pred   = pos;
    if (!s_cur)    run_n = (run == RUN_SAT) ? run : run + 11'd1;
    else if (rise) run_n = '0;
    if (pos.x == X_LAST) begin
      pred.x = '0;
      pred.y = (pos.y == Y_LAST) ? '0 : pos.y + 9'd1;
    end else begin
      pred.x = pos.x + 10'd1;
    end
    pos_n = pred;
    if (is_v) begin
      pos_n  = '{x: X_VRISE, y: Y_VRISE};
      seen_n = 1'b1;
      lcnt_n = '0;
      tcnt_n = '0;
    end else if (is_h) begin
      pos_n.x = X_HRISE;
      tcnt_n  = '0;
      if (pred.x == X_HRISE) begin
        if (seen_v) begin
          if (lcnt != L_FULL) lcnt_n = lcnt + LW'(1);
          if (lcnt_n == L_FULL) lock_n = 1'b1;
        end
      end else begin
        // hsync landed off the predicted column: realign, start over
        lock_n = 1'b0;
        lcnt_n = '0;
        seen_n = 1'b0;
      end
    end else if (tcnt >= T_LAST) begin
      tcnt_n = T_FULL;
      lock_n = 1'b0;
      lcnt_n = '0;
      seen_n = 1'b0;
    end else begin
      tcnt_n = tcnt + 12'd1;
    end
    pv_n = lock_n && (pos_n.x < X_VIS) && (pos_n.y < Y_VIS);
  end

  // Prescaler and two-flop input synchronizers, every clk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      sync_pipe <= 2'b11;
      vid_pipe  <= 2'b00;
    end else begin
      presc     <= tick_c ? '0 : presc + PW'(1);
      sync_pipe <= {sync_pipe[0], sync_in_};
      vid_pipe  <= {vid_pipe[0], video_in};
    end
  end

  // Registered strobes: one clk wide, aligned with the evaluating tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick      <= 1'b0;
      hsync_evt <= 1'b0;
      vsync_evt <= 1'b0;
      pix_valid <= 1'b0;
      pix       <= 1'b0;
    end else begin
      tick      <= tick_c;
      hsync_evt <= tick_c & is_h;
      vsync_evt <= tick_c & is_v;
      pix_valid <= tick_c & pv_n;
      pix       <= tick_c & pv_n & v_cur;
    end
  end

  // Sample-rate state, advanced only on ticks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_prev <= 1'b1;
      run    <= '0;
      tcnt   <= '0;
      lcnt   <= '0;
      seen_v <= 1'b0;
      locked <= 1'b0;
      pos    <= '0;
    end else if (tick_c) begin
      s_prev <= s_cur;
      run    <= run_n;
      tcnt   <= tcnt_n;
      lcnt   <= lcnt_n;
      seen_v <= seen_n;
      locked <= lock_n;
      pos    <= pos_n;
    end
  end
endmodule

// File: tb/tb_tv_sync_decoder.sv
// Directed bench for tv_sync_decoder on a scaled-down raster.
module tb_tv_sync_decoder;
  localparam int CD = 5, LL = 64, FL = 20, HV = 40, VV = 12;
  localparam int HR = 56, VRX = 32, VRY = 14, HMIN = 4, HMAX = 7, VMIN = 24;
  localparam int LKL = 4, TMO = 256, HSW = 5;

  logic clk = 1'b0, rst = 1'b1, sync_in_ = 1'b1, video_in = 1'b0;
  logic tick, hsync_evt, vsync_evt, locked, pix_valid, pix;
  logic [9:0] xpos;
  logic [8:0] ypos;

  tv_sync_decoder #(
    .CLK_DIV(CD), .LINE_LEN(LL), .FRAME_LINES(FL), .H_VIS(HV), .V_VIS(VV),
    .H_RISE(HR), .V_RISE_X(VRX), .V_RISE_Y(VRY), .HS_MIN(HMIN), .HS_MAX(HMAX),
    .VS_MIN(VMIN), .LOCK_LINES(LKL), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .sync_in_(sync_in_), .video_in(video_in),
    .tick(tick), .hsync_evt(hsync_evt), .vsync_evt(vsync_evt), .locked(locked),
    .pix_valid(pix_valid), .pix(pix), .xpos(xpos), .ypos(ypos)
  );

  always #10 clk = ~clk;

  typedef struct {
    int run;
    bit eh;
    bit ev;
  } vec_t;

  vec_t tbl[8];
  int chk_cnt = 0, pass_cnt = 0;
  int tick_err = 0, strobe_err = 0, tbl_evt_err = 0, tbl_pos_err = 0;
  logic [4:0] hist;
  int ex, ey;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  // One sample period: pins change away from the edge, sampled #1 after tick edge
  task automatic samp(input logic s, input logic v);
    sync_in_ = s;
    video_in = v;
    hist = '0;
    for (int e = 0; e < CD; e++) begin
      @(posedge clk); #1;
      hist[e] = tick;
      if (tick !== (e == CD - 1)) tick_err++;
      if (e != CD - 1 && (hsync_evt !== 1'b0 || vsync_evt !== 1'b0 || pix_valid !== 1'b0))
        strobe_err++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sync_in_ = 1'($urandom_range(0, 1));
    video_in = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {tick, hsync_evt, vsync_evt, locked, pix_valid, pix, xpos, ypos}, 0);
    @(negedge clk);
    sync_in_ = 1'b1;
    video_in = 1'b0;
    rst = 1'b0;
  endtask

  // Table-phase sample with a spec-level position model
  task automatic tsamp(input logic s, input bit eh, input bit ev);
    samp(s, 1'b0);
    if (ex == LL - 1) begin ex = 0; ey = (ey == FL - 1) ? 0 : ey + 1; end
    else ex++;
    if (ev) begin ex = VRX; ey = VRY; end
    else if (eh) ex = HR;
    if (hsync_evt !== eh || vsync_evt !== ev) tbl_evt_err++;
    if (int'(xpos) != ex || int'(ypos) != ey) tbl_pos_err++;
  endtask

  initial begin
    int err_evt, err_lock, err_pos, err_pv, err_pix;
    int pvc, bc, vc0, vc1, aligned, elock, lock_seen, relock_seen, lx, ly, rx, ry;
    int dead_err, nv_err, nv_hs;
    logic s, v;
    bit eh, ev, epv, epix;

    tbl[0] = '{3, 0, 0};
    tbl[1] = '{4, 1, 0};
    tbl[2] = '{7, 1, 0};
    tbl[3] = '{8, 0, 0};
    tbl[4] = '{23, 0, 0};
    tbl[5] = '{24, 0, 1};
    tbl[6] = '{40, 0, 1};
    tbl[7] = '{2100, 0, 1};

    // Reset and first tick timing
    do_reset();
    ex = 0; ey = 0;
    tsamp(1'b1, 0, 0);
    check("first_tick_at_clk5", 32'(hist), 32'(5'b10000));

    // Classification boundaries
    for (int r = 0; r < 8; r++) begin
      repeat (10) tsamp(1'b1, 0, 0);
      repeat (tbl[r].run) tsamp(1'b0, 0, 0);
      tsamp(1'b1, tbl[r].eh, tbl[r].ev);
      check($sformatf("row%0d_run%0d_hsync", r, tbl[r].run), 32'(hsync_evt), 32'(tbl[r].eh));
      check($sformatf("row%0d_run%0d_vsync", r, tbl[r].run), 32'(vsync_evt), 32'(tbl[r].ev));
      check($sformatf("row%0d_xpos", r), 32'(xpos), ex);
      check($sformatf("row%0d_ypos", r), 32'(ypos), ey);
    end
    check("table_spurious_events", tbl_evt_err, 0);
    check("table_position_track", tbl_pos_err, 0);

    // Loopback from generator: lock, full frame, glitch, misalign, relock
    do_reset();
    err_evt = 0; err_lock = 0; err_pos = 0; err_pv = 0; err_pix = 0;
    pvc = 0; bc = 0; vc0 = 0; vc1 = 0; aligned = 0; elock = 0;
    lock_seen = 0; relock_seen = 0; lx = 0; ly = 0; rx = 0; ry = 0;
    for (int f = 0; f < 4; f++)
      for (int gy = 0; gy < FL; gy++)
        for (int gx = 0; gx < LL; gx++) begin
          if (gy == VRY) s = !(gx < VRX);
          else if (f == 2 && gy == 16) s = !(gx >= HR - HSW + 3 && gx < HR + 3);
          else s = !(gx >= HR - HSW && gx < HR);
          if (f == 2 && gy == 10 && gx >= 20 && gx < 23) s = 1'b0;
          v = (gx < HV && gy < VV) && (gx == 0 || gx == HV - 1 || gy == 0 || gy == VV - 1);
          eh = (gy != VRY) && (gx == ((f == 2 && gy == 16) ? HR + 3 : HR));
          ev = (gy == VRY) && (gx == VRX);
          if ((f == 0 || f == 3) && gy == 18 && gx == HR) elock = 1;
          if (f == 2 && gy == 16 && gx == HR + 3) begin elock = 0; aligned = 0; end
          if (ev && f == 0) aligned = 1;
          if (f == 2 && gy == 17 && gx == HR) aligned = 1;
          samp(s, v);
          epv = elock && gx < HV && gy < VV;
          epix = epv && v;
          if (hsync_evt !== eh || vsync_evt !== ev) err_evt++;
          if (locked !== 1'(elock)) err_lock++;
          if (aligned != 0 && (int'(xpos) != gx || int'(ypos) != gy)) err_pos++;
          if (pix_valid !== epv) err_pv++;
          if (pix !== epix) err_pix++;
          if (f == 0 && vsync_evt === 1'b1) vc0++;
          if (f == 1) begin
            if (pix_valid === 1'b1) pvc++;
            if (pix_valid === 1'b1 && pix === 1'b1) bc++;
            if (vsync_evt === 1'b1) vc1++;
          end
          if (f == 0 && lock_seen == 0 && locked === 1'b1) begin
            lock_seen = 1; lx = int'(xpos); ly = int'(ypos);
          end
          if (f == 3 && relock_seen == 0 && locked === 1'b1) begin
            relock_seen = 1; rx = int'(xpos); ry = int'(ypos);
          end
          if (f == 2 && gy == 10 && gx == 23) begin
            check("glitch_locked_kept", 32'(locked), 1);
            check("glitch_xpos_kept", 32'(xpos), 23);
          end
          if (f == 2 && gy == 16 && gx == HR + 3) begin
            check("misalign_hsync_evt", 32'(hsync_evt), 1);
            check("misalign_unlock", 32'(locked), 0);
            check("misalign_xpos", 32'(xpos), HR);
          end
        end
    check("loop_event_errors", err_evt, 0);
    check("loop_lock_errors", err_lock, 0);
    check("loop_position_errors", err_pos, 0);
    check("loop_pix_valid_errors", err_pv, 0);
    check("loop_pix_errors", err_pix, 0);
    check("frame0_vsync_count", vc0, 1);
    check("frame1_vsync_count", vc1, 1);
    check("frame1_pix_valid_count", pvc, HV * VV);
    check("frame1_border_pixels", bc, 2 * HV + 2 * VV - 4);
    check("lock_rise_xpos", lx, HR);
    check("lock_rise_ypos", ly, VRY + LKL);
    check("relock_xpos", rx, HR);
    check("relock_ypos", ry, VRY + LKL);

    // Dead input: last hsync was 7 ticks ago at end of frame
    dead_err = 0;
    for (int n = 8; n <= TMO + 4; n++) begin
      samp(1'b1, 1'b0);
      if (hsync_evt !== 1'b0 || vsync_evt !== 1'b0) dead_err++;
      if (n == TMO - 1) check("timeout_still_locked", 32'(locked), 1);
      if (n == TMO) check("timeout_drops_lock", 32'(locked), 0);
    end
    check("dead_no_events", dead_err, 0);

    // Asynchronous reset mid-frame clears outputs without a clock edge
    rst = 1'b1;
    #3;
    check("midframe_reset_outputs", {tick, hsync_evt, vsync_evt, locked, pix_valid, pix, xpos, ypos}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Hsyncs alone, without a vsync, must not lock
    nv_err = 0; nv_hs = 0;
    for (int gy = 0; gy < 6; gy++)
      for (int gx = 0; gx < LL; gx++) begin
        samp(!(gx >= HR - HSW && gx < HR), 1'b0);
        if (locked !== 1'b0) nv_err++;
        if (hsync_evt === 1'b1) nv_hs++;
      end
    check("no_vsync_no_lock", nv_err, 0);
    check("no_vsync_hsync_count", nv_hs, 6);

    check("tick_strobe_timing", tick_err, 0);
    check("strobes_only_on_tick", strobe_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
